// File: rtl/spgd_sequencer.sv
// spgd_sequencer: SPGD iteration sequencer (J+ measure -> J- measure -> U update -> RNG perturb).
// Optional ADC_DONE watchdog is built when SPGD_SEQ_ADC_TIMEOUT_EN is defined.
module spgd_sequencer #(
  parameter int COUNT_WIDTH = 32,
  parameter int ITER_WIDTH  = 32,
  parameter int ADC_TIME    = 1036,
  parameter int MATH_TIME   = 10,
  parameter int UPDATE_TIME = 40,
  parameter int RNG_TIME    = 100,
  parameter int TIMEOUT     = 4096
) (
  input  logic                   i_adc_clk,
  input  logic                   i_rst_n,
  input  logic                   i_fsm_en,
  input  logic                   i_mode,
  input  logic                   i_ext_trig,
  input  logic                   i_adc_done,
  input  logic [COUNT_WIDTH-1:0] i_j_time,
  input  logic [ITER_WIDTH-1:0]  i_iter_limit,
  output logic                   o_adc_en,
  output logic                   o_reg_rst,
  output logic                   o_rng_clk,
  output logic                   o_j_p_wrt,
  output logic                   o_j_m_wrt,
  output logic                   o_u_wrt,
  output logic                   o_delta_u_wrt,
  output logic [1:0]             o_dac_sel,
  output logic [3:0]             o_fsm_state,
  output logic [ITER_WIDTH-1:0]  o_iter_count,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int DW = COUNT_WIDTH + 2;

  typedef enum logic [3:0] {
    S_STOP   = 4'd0,  S_WAIT_A = 4'd1,  S_ADC_A = 4'd2,  S_MATH_A = 4'd3,
    S_JP_WR  = 4'd4,  S_WAIT_B = 4'd5,  S_ADC_B = 4'd6,  S_MATH_B = 4'd7,
    S_JM_WR  = 4'd8,  S_MATH_C = 4'd9,  S_U_WR  = 4'd10, S_RNG    = 4'd11,
    S_DU_WR  = 4'd12, S_WAIT_C = 4'd13, S_DONE  = 4'd14, S_ERR    = 4'd15
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [COUNT_WIDTH-1:0]  r_cnt;
  logic [COUNT_WIDTH-1:0]  w_load;
  logic                    w_cnt_zero;
  logic                    r_ext;
  logic [2:0]              r_sync;
  logic                    r_edge;
  logic [ITER_WIDTH-1:0]   r_iter;
  logic [ITER_WIDTH-1:0]   w_iter_inc;
  logic signed [DW-1:0]    w_j_ext;
  logic signed [DW-1:0]    w_dur_a;
  logic signed [DW-1:0]    w_dur_b;
  logic signed [DW-1:0]    w_dur_c;
  logic                    r_adc_en;
  logic                    r_reg_rst;
  logic                    r_rng_clk;
  logic                    r_j_p_wrt;
  logic                    r_j_m_wrt;
  logic                    r_u_wrt;
  logic                    r_du_wrt;
  logic [1:0]              r_dac_sel;
  logic                    r_done;

  // Duration N -> counter preload N-1, clamped so N lands in [1, 2^COUNT_WIDTH].
  function automatic logic [COUNT_WIDTH-1:0] f_load(input logic signed [DW-1:0] dur);
    logic signed [DW-1:0] v;
    v = dur - DW'(1);
    if (v[DW-1])                     return '0;
    else if (|v[DW-2:COUNT_WIDTH])   return '1;
    else                             return v[COUNT_WIDTH-1:0];
  endfunction

  assign w_j_ext    = $signed({2'b00, i_j_time});
  assign w_dur_a    = w_j_ext - DW'(ADC_TIME);
  assign w_dur_b    = w_j_ext - DW'(ADC_TIME) - DW'(UPDATE_TIME);
  assign w_dur_c    = (w_j_ext <<< 1) - DW'(RNG_TIME);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_iter_inc = r_iter + ITER_WIDTH'(1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_STOP:   w_next = S_WAIT_A;
      S_WAIT_A: if (r_ext ? r_edge : w_cnt_zero) w_next = S_ADC_A;
      S_ADC_A: begin
        if (i_adc_done) w_next = S_MATH_A;
`ifdef SPGD_SEQ_ADC_TIMEOUT_EN
        else if (w_cnt_zero) w_next = S_ERR;
`endif
      end
      S_MATH_A: if (w_cnt_zero) w_next = S_JP_WR;
      S_JP_WR:  w_next = S_WAIT_B;
      S_WAIT_B: if (r_ext ? r_edge : w_cnt_zero) w_next = S_ADC_B;
      S_ADC_B: begin
        if (i_adc_done) w_next = S_MATH_B;
`ifdef SPGD_SEQ_ADC_TIMEOUT_EN
        else if (w_cnt_zero) w_next = S_ERR;
`endif
      end
      S_MATH_B: if (w_cnt_zero) w_next = S_JM_WR;
      S_JM_WR:  w_next = S_MATH_C;
      S_MATH_C: if (w_cnt_zero) w_next = S_U_WR;
      S_U_WR:   w_next = S_RNG;
      S_RNG:    if (w_cnt_zero) w_next = S_DU_WR;
      S_DU_WR:  w_next = ((i_iter_limit != '0) && (w_iter_inc == i_iter_limit)) ? S_DONE : S_WAIT_C;
      S_WAIT_C: if (w_cnt_zero) w_next = S_WAIT_A;
      S_DONE:   w_next = S_DONE;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_STOP;
    endcase
    if (!i_fsm_en) w_next = S_STOP;
  end

  always_comb begin
    w_load = '0;
    case (w_next)
      S_WAIT_A:         w_load = i_mode ? '0 : f_load(w_dur_a);
      S_WAIT_B:         w_load = i_mode ? '0 : f_load(w_dur_b);
      S_WAIT_C:         w_load = i_mode ? '0 : f_load(w_dur_c);
      S_ADC_A, S_ADC_B: w_load = COUNT_WIDTH'(TIMEOUT - 1);
      S_MATH_A, S_MATH_B: w_load = COUNT_WIDTH'(MATH_TIME - 1);
      S_MATH_C:         w_load = COUNT_WIDTH'(UPDATE_TIME - 1);
      S_RNG:            w_load = COUNT_WIDTH'(RNG_TIME - 1);
      default:          w_load = '0;
    endcase
  end

  always_ff @(posedge i_adc_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_STOP;
      r_cnt   <= '0;
      r_ext   <= 1'b0;
      r_sync  <= '0;
      r_edge  <= 1'b0;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[1:0], i_ext_trig};
      // Registered edge: a WAIT exits 3 cycles after the trigger is first sampled.
      r_edge  <= r_sync[1] & ~r_sync[2];
      if (w_next != r_state) r_cnt <= w_load;
      else if (!w_cnt_zero)  r_cnt <= r_cnt - COUNT_WIDTH'(1);
      if ((w_next != r_state) && (w_next inside {S_WAIT_A, S_WAIT_B, S_WAIT_C}))
        r_ext <= i_mode;
      if (w_next == S_STOP)       r_iter <= '0;
      else if (r_state == S_DU_WR) r_iter <= w_iter_inc;
    end
  end

  always_ff @(posedge i_adc_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_adc_en  <= 1'b0;
      r_reg_rst <= 1'b1;
      r_rng_clk <= 1'b0;
      r_j_p_wrt <= 1'b0;
      r_j_m_wrt <= 1'b0;
      r_u_wrt   <= 1'b0;
      r_du_wrt  <= 1'b0;
      r_dac_sel <= 2'b00;
      r_done    <= 1'b0;
    end else begin
      r_adc_en  <= w_next inside {S_ADC_A, S_MATH_A, S_JP_WR, S_ADC_B, S_MATH_B, S_JM_WR};
      r_reg_rst <= (w_next == S_STOP);
      r_rng_clk <= ((r_state == S_RNG) && (w_next == S_RNG)) ? ~r_rng_clk : 1'b0;
      r_j_p_wrt <= (w_next == S_JP_WR);
      r_j_m_wrt <= (w_next == S_JM_WR);
      r_u_wrt   <= (w_next == S_U_WR);
      r_du_wrt  <= (w_next == S_DU_WR);
      r_done    <= (w_next == S_DONE);
      if (w_next inside {[S_WAIT_A:S_JP_WR]})      r_dac_sel <= 2'b01;
      else if (w_next inside {[S_WAIT_B:S_U_WR]})  r_dac_sel <= 2'b10;
      else if (w_next inside {[S_RNG:S_WAIT_C]})   r_dac_sel <= 2'b11;
      else                                         r_dac_sel <= 2'b00;
    end
  end

`ifdef SPGD_SEQ_ADC_TIMEOUT_EN
  logic r_err;
  always_ff @(posedge i_adc_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_err <= 1'b0;
    else          r_err <= (w_next == S_ERR);
  end
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  assign o_adc_en      = r_adc_en;
  assign o_reg_rst     = r_reg_rst;
  assign o_rng_clk     = r_rng_clk;
  assign o_j_p_wrt     = r_j_p_wrt;
  assign o_j_m_wrt     = r_j_m_wrt;
  assign o_u_wrt       = r_u_wrt;
  assign o_delta_u_wrt = r_du_wrt;
  assign o_dac_sel     = r_dac_sel;
  assign o_fsm_state   = r_state;
  assign o_iter_count  = r_iter;
  assign o_done        = r_done;

endmodule
